// File: rtl/periph_wb_reg_bridge.sv
// Wishbone-classic slave to peripheral reg_cs/reg_ack request bus.
// Optional hung-access timeout: define PERIPH_BRIDGE_TIMEOUT_EN.
module periph_wb_reg_bridge #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        app_clk,
    input  logic        reset_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [8:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        reg_cs,
    output logic        reg_wr,
    output logic [8:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_be,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN} state_t;

    state_t      r_state, w_next;
    logic        r_resp_err;
    logic [31:0] r_dat;
    logic [7:0]  r_err_cnt;
    logic        r_wr;
    logic [8:0]  r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic w_req, w_mapped, w_timeout;
    logic w_accept, w_load_err, w_load_rd;

    assign w_req    = wbs_cyc_i & wbs_stb_i;
    assign w_mapped = (wbs_adr_i[8:6] <= 3'd4);

`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_to_cnt;

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_REQ || r_state == S_DRAIN) && (w_next == r_state)) begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    // reg_ack on the timeout edge wins
    assign w_timeout = (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1)) && !reg_ack;
`else
    // TIMEOUT_CYC is at least 2, so this is constant 0
    assign w_timeout = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_load_err = 1'b0;
        w_load_rd  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_mapped) begin
                        w_accept = 1'b1;
                        w_next   = S_REQ;
                    end else begin
                        w_load_err = 1'b1;
                        w_next     = S_RESP;
                    end
                end
            end
            S_REQ: begin
                // an ack or timeout coinciding with master abort ends silently
                if (reg_ack) begin
                    if (wbs_cyc_i) begin
                        w_load_rd = !r_wr;
                        w_next    = S_RESP;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else if (w_timeout) begin
                    if (wbs_cyc_i) begin
                        w_load_err = 1'b1;
                        w_next     = S_RESP;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else if (!wbs_cyc_i) begin
                    w_next = S_DRAIN;
                end
            end
            S_RESP:  w_next = S_IDLE;
            S_DRAIN: begin
                if (reg_ack || w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_err <= 1'b0;
            r_dat      <= '0;
            r_err_cnt  <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
        end else begin
            if (w_accept) begin
                r_wr    <= wbs_we_i;
                r_addr  <= wbs_adr_i;
                r_wdata <= wbs_dat_i;
                r_be    <= wbs_sel_i;
            end
            if (w_load_err) begin
                r_dat <= ERR_DATA;
            end else if (w_load_rd) begin
                r_dat <= reg_rdata;
            end
            if (w_load_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_next == S_RESP) begin
                r_resp_err <= w_load_err;
            end
        end
    end

    assign reg_cs    = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign reg_wr    = r_wr;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_be    = r_be;
    assign wbs_dat_o = r_dat;
    assign wbs_ack_o = (r_state == S_RESP) && !r_resp_err;
    assign wbs_err_o = (r_state == S_RESP) && r_resp_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_periph_wb_reg_bridge.sv
// Scoreboard bench for periph_wb_reg_bridge; timeout cases need PERIPH_BRIDGE_TIMEOUT_EN.
module tb_periph_wb_reg_bridge;

    localparam int TO = 8;
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        app_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [8:0]  wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o;
    logic        reg_cs, reg_wr;
    logic [8:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata = '0;
    logic        reg_ack = 1'b0;
    logic [7:0]  err_cnt;

    periph_wb_reg_bridge #(.TIMEOUT_CYC(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .app_clk(app_clk), .reset_n(reset_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata),
        .reg_ack(reg_ack), .err_cnt(err_cnt)
    );

    always #5 app_clk = ~app_clk;

    typedef struct {
        logic        is_err;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0, n_fail = 0, n_resp = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // response monitor: pops one expectation per ack/err pulse
    exp_t mon_e;
    always @(negedge app_clk) begin
        if (reset_n && (wbs_ack_o || wbs_err_o)) begin
            n_resp++;
            check_eq("ack_err_exclusive", {31'b0, wbs_ack_o & wbs_err_o}, 32'd0);
            if (sb_q.size() == 0) begin
                check_eq("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("resp_is_err", {31'b0, wbs_err_o}, {31'b0, mon_e.is_err});
                check_eq("resp_dat", wbs_dat_o, mon_e.dat);
            end
        end
    end

    // peripheral model: acks in the ack_after-th cycle of reg_cs (0 = never)
    int          ack_after = 0;
    logic [31:0] rdata_val = '0;
    int          cs_cycles = 0, last_cs_len = 0, cs_rises = 0, unstable = 0;
    bit          pulse_ack = 1'b0;
    logic [8:0]  cap_addr = '0;
    logic        cap_wr = 1'b0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_be = '0;

    always @(posedge app_clk) begin
        #2;
        reg_rdata = rdata_val;
        if (reg_cs) begin
            cs_cycles++;
            if (cs_cycles == 1) begin
                cs_rises++;
                cap_addr  = reg_addr;
                cap_wr    = reg_wr;
                cap_wdata = reg_wdata;
                cap_be    = reg_be;
            end else if (reg_addr !== cap_addr || reg_wr !== cap_wr ||
                         reg_wdata !== cap_wdata || reg_be !== cap_be) begin
                unstable++;
            end
            reg_ack = (ack_after != 0) && (cs_cycles == ack_after);
        end else begin
            if (cs_cycles != 0) last_cs_len = cs_cycles;
            cs_cycles = 0;
            reg_ack   = 1'b0;
        end
        if (pulse_ack) begin
            reg_ack   = 1'b1;
            pulse_ack = 1'b0;
        end
    end

    logic [31:0] model_dat = '0;
    int          model_errcnt = 0;

    task automatic wb_access(input logic we, input logic [8:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input int ack_at, input logic [31:0] rd,
                             output int lat);
        exp_t e;
        bit   err;
        bit   got;
        err = (adr[8:6] > 3'd4) || (TO_EN && (ack_at == 0 || ack_at > TO));
        if (err) model_dat = 32'hDEAD_BEEF;
        else if (!we) model_dat = rd;
        if (err && model_errcnt < 255) model_errcnt++;
        e.is_err = err;
        e.dat    = model_dat;
        sb_q.push_back(e);
        ack_after = ack_at;
        rdata_val = rd;
        @(posedge app_clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge app_clk);
            lat++;
            @(negedge app_clk);
            got = wbs_ack_o | wbs_err_o;
        end
        if (!got) check_eq("resp_wait", 32'd0, 32'd1);
        @(posedge app_clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check_eq("err_cnt", {24'b0, err_cnt}, model_errcnt);
    endtask

    initial begin
        int          lat;
        int          prev;
        logic [8:0]  a;

        repeat (3) @(posedge app_clk);
        #1;
        check_eq("rst_reg_cs", {31'b0, reg_cs}, 32'd0);
        check_eq("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
        check_eq("rst_err", {31'b0, wbs_err_o}, 32'd0);
        check_eq("rst_dat", wbs_dat_o, 32'd0);
        check_eq("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check_eq("rst_reg_bus", {reg_wr, reg_addr, reg_be} | {18'b0, reg_wdata != 0}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge app_clk);

        // read, ack in third reg_cs cycle
        wb_access(1'b0, 9'h044, 32'h0, 4'hF, 3, 32'h0000_00A5, lat);
        check_eq("rd_cs_len", last_cs_len, 32'd3);
        check_eq("rd_addr", {23'b0, cap_addr}, 32'h044);
        check_eq("rd_wr", {31'b0, cap_wr}, 32'd0);
        check_eq("rd_latency", lat, 32'd4);

        // write, ack in first reg_cs cycle; read data bus carries junk
        wb_access(1'b1, 9'h0C8, 32'h1234_5678, 4'hF, 1, 32'hFFFF_0000, lat);
        check_eq("wr_cs_len", last_cs_len, 32'd1);
        check_eq("wr_wr", {31'b0, cap_wr}, 32'd1);
        check_eq("wr_wdata", cap_wdata, 32'h1234_5678);
        check_eq("wr_be", {28'b0, cap_be}, 32'hF);
        check_eq("wr_latency", lat, 32'd2);

        // unmapped sub-block 5
        prev = cs_rises;
        wb_access(1'b0, 9'h150, 32'h0, 4'hF, 1, 32'h0, lat);
        check_eq("unmapped_no_cs", cs_rises, prev);

        // stray reg_ack in IDLE
        prev = n_resp;
        pulse_ack = 1'b1;
        repeat (3) @(posedge app_clk);
        #1;
        check_eq("idle_ack_ignored", n_resp, prev);
        check_eq("idle_ack_no_cs", {31'b0, reg_cs}, 32'd0);

        // master abort one cycle into REQ
        prev = n_resp;
        ack_after = 5;
        @(posedge app_clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 9'h084;
        @(posedge app_clk); #1;
        @(posedge app_clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        repeat (8) @(posedge app_clk);
        #1;
        check_eq("abort_cs_len", last_cs_len, 32'd5);
        check_eq("abort_no_resp", n_resp, prev);
        check_eq("abort_cs_low", {31'b0, reg_cs}, 32'd0);
        wb_access(1'b0, 9'h100, 32'h0, 4'h3, 2, 32'hCAFE_F00D, lat);
        check_eq("after_abort_latency", lat, 32'd3);

`ifdef PERIPH_BRIDGE_TIMEOUT_EN
        wb_access(1'b0, 9'h040, 32'h0, 4'hF, 0, 32'h0, lat);
        check_eq("to_cs_len", last_cs_len, TO);
        prev = n_resp;
        pulse_ack = 1'b1;
        repeat (3) @(posedge app_clk);
        check_eq("to_late_ack_ignored", n_resp, prev);
        wb_access(1'b0, 9'h040, 32'h0, 4'hF, TO, 32'h5A5A_5A5A, lat);
        check_eq("to_edge_cs_len", last_cs_len, TO);
`endif

        // error counter saturation
        for (int i = 0; i < 300; i++) begin
            a = {3'(5 + (i % 3)), 6'(i)};
            wb_access(1'(i % 2), a, 32'(i), 4'hF, 1, 32'h0, lat);
        end
        check_eq("err_cnt_sat", {24'b0, err_cnt}, 32'h0000_00FF);
        check_eq("reg_bus_stable", unstable, 32'd0);

        // asynchronous reset in the middle of REQ
        ack_after = 0;
        @(posedge app_clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 9'h004;
        @(posedge app_clk); #1;
        check_eq("pre_rst_cs", {31'b0, reg_cs}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_cs", {31'b0, reg_cs}, 32'd0);
        check_eq("midrst_ack", {31'b0, wbs_ack_o}, 32'd0);
        check_eq("midrst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check_eq("midrst_dat", wbs_dat_o, 32'd0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        model_errcnt = 0;
        model_dat    = '0;
        @(posedge app_clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge app_clk);

        wb_access(1'b0, 9'h0C0, 32'h0, 4'hF, 2, 32'h0BAD_F00D, lat);
        check_eq("post_rst_latency", lat, 32'd3);

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
